// File: rtl/wishbone_register_slave.sv
// wishbone_register_slave
//   Wishbone classic-cycle responder holding a bank of 32-bit registers.
//   Word 0 is a read-only ID word; words 1..NUM_REGS-1 are writable with
//   per-byte lane enables. Every captured request is answered by exactly one
//   ack (legal) or err (illegal) pulse, WAIT_STATES cycles after capture,
//   unless cyc drops while waiting (silent abort) or reset intervenes.
//
// Ports
//   in_clock     : sole clock, rising edge
//   in_reset     : synchronous, active-high reset
//   in_wb_cyc    : bus cycle active
//   in_wb_stb    : strobe; request valid when cyc & stb
//   in_wb_we     : 1 = write, 0 = read
//   in_wb_adr    : byte address; word index = adr[21:2]
//   in_wb_sel    : byte lane enables
//   in_wb_wdat   : write data
//   out_wb_ack   : normal termination, one-cycle pulse
//   out_wb_err   : error termination, one-cycle pulse
//   out_wb_rdat  : read data, held until the next response
module wishbone_register_slave #(
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hB10C_0001
) (
  input  logic        in_clock,
  input  logic        in_reset,
  input  logic        in_wb_cyc,
  input  logic        in_wb_stb,
  input  logic        in_wb_we,
  input  logic [21:0] in_wb_adr,
  input  logic [3:0]  in_wb_sel,
  input  logic [31:0] in_wb_wdat,
  output logic        out_wb_ack,
  output logic        out_wb_err,
  output logic [31:0] out_wb_rdat
);

  localparam int unsigned IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [3:0]  WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;
  logic        capture, respond;

  // Request decode straight from the bus
  logic        req;
  logic [19:0] in_idx;
  logic        in_legal;

  // Captured request
  logic          lat_we;
  logic          lat_legal;
  logic [IW-1:0] lat_idx;
  logic [3:0]    lat_sel;
  logic [31:0]   lat_wdat;

  // Request being answered this edge
  logic          rsp_we;
  logic          rsp_legal;
  logic [IW-1:0] rsp_idx;
  logic [3:0]    rsp_sel;
  logic [31:0]   rsp_wdat;
  logic [31:0]   rd_word;

  logic [31:0] regs [NUM_REGS];

  assign req    = in_wb_cyc & in_wb_stb;
  assign in_idx = in_wb_adr[21:2];
  assign in_legal = (in_wb_adr[1:0] == 2'b00)
                 && (32'(in_idx) < NUM_REGS)
                 && !(in_wb_we && (in_idx == '0));

  // With zero wait states the response happens on the capture edge itself,
  // so the live bus values stand in for the not-yet-latched ones.
  always_comb begin
    if (state == ST_IDLE) begin
      rsp_we    = in_wb_we;
      rsp_legal = in_legal;
      rsp_idx   = in_idx[IW-1:0];
      rsp_sel   = in_wb_sel;
      rsp_wdat  = in_wb_wdat;
    end else begin
      rsp_we    = lat_we;
      rsp_legal = lat_legal;
      rsp_idx   = lat_idx;
      rsp_sel   = lat_sel;
      rsp_wdat  = lat_wdat;
    end
  end

  assign rd_word = (rsp_idx == '0) ? ID_VALUE : regs[rsp_idx];

  // Next-state logic
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    capture       = 1'b0;
    respond       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            respond    = 1'b1;
          end else begin
            state_next    = ST_WAIT;
            wait_cnt_next = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        // Dropping cyc abandons the request silently, even on the last wait edge
        if (!in_wb_cyc) begin
          state_next    = ST_IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == '0) begin
          state_next = ST_RESP;
          respond    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Request capture; bus changes after this are ignored
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      lat_we    <= 1'b0;
      lat_legal <= 1'b0;
      lat_idx   <= '0;
      lat_sel   <= '0;
      lat_wdat  <= '0;
    end else if (capture) begin
      lat_we    <= in_wb_we;
      lat_legal <= in_legal;
      lat_idx   <= in_idx[IW-1:0];
      lat_sel   <= in_wb_sel;
      lat_wdat  <= in_wb_wdat;
    end
  end

  // Response outputs; rdat holds between responses
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      out_wb_ack  <= 1'b0;
      out_wb_err  <= 1'b0;
      out_wb_rdat <= '0;
    end else begin
      out_wb_ack <= respond & rsp_legal;
      out_wb_err <= respond & ~rsp_legal;
      if (respond) begin
        out_wb_rdat <= (rsp_legal && !rsp_we) ? rd_word : '0;
      end
    end
  end

  // Register bank; word 0 is never written since writes to it are illegal
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (respond && rsp_legal && rsp_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (rsp_sel[b]) begin
          regs[rsp_idx][8*b +: 8] <= rsp_wdat[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_register_slave.sv
// tb_wishbone_register_slave
//   Directed plus randomized bench for wishbone_register_slave. A timeline
//   model (edge counter, capture/response edge numbers, plain word array)
//   predicts ack/err/rdat; a negedge process compares every cycle after reset.
module tb_wishbone_register_slave;

  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned WS       = 2;
  localparam logic [31:0] ID       = 32'hB10C_0001;

  logic        in_clock = 1'b0;
  logic        in_reset;
  logic        in_wb_cyc, in_wb_stb, in_wb_we;
  logic [21:0] in_wb_adr;
  logic [3:0]  in_wb_sel;
  logic [31:0] in_wb_wdat;
  logic        out_wb_ack, out_wb_err;
  logic [31:0] out_wb_rdat;

  int vectors = 0;
  int miscompares = 0;

  wishbone_register_slave #(
    .NUM_REGS(NUM_REGS),
    .WAIT_STATES(WS),
    .ID_VALUE(ID)
  ) dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .in_wb_cyc(in_wb_cyc),
    .in_wb_stb(in_wb_stb),
    .in_wb_we(in_wb_we),
    .in_wb_adr(in_wb_adr),
    .in_wb_sel(in_wb_sel),
    .in_wb_wdat(in_wb_wdat),
    .out_wb_ack(out_wb_ack),
    .out_wb_err(out_wb_err),
    .out_wb_rdat(out_wb_rdat)
  );

  always #5 in_clock = ~in_clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline reference model ----------------
  logic [31:0] mem [0:255];
  logic        m_ack = 1'b0, m_err = 1'b0;
  logic [31:0] m_rdat = '0;
  int          n = 0;
  bit          pending = 0;
  int          cap_edge = 0, resp_edge = 0, idle_from = 0;
  logic        cap_we;
  logic [21:0] cap_adr;
  logic [3:0]  cap_sel;
  logic [31:0] cap_wdat;

  always @(posedge in_clock) begin
    int idx;
    bit legal;
    n++;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (in_reset) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      m_rdat    = '0;
      pending   = 0;
      idle_from = n + 1;
    end else begin
      if (pending && n > cap_edge && !in_wb_cyc) begin
        pending   = 0;
        idle_from = n + 1;
      end
      if (!pending && n >= idle_from && in_wb_cyc && in_wb_stb) begin
        cap_we = in_wb_we; cap_adr = in_wb_adr; cap_sel = in_wb_sel; cap_wdat = in_wb_wdat;
        cap_edge  = n;
        resp_edge = n + int'(WS);
        pending   = 1;
      end
      if (pending && n == resp_edge) begin
        idx   = int'(cap_adr[21:2]);
        legal = (cap_adr[1:0] == 2'b00) && (idx < int'(NUM_REGS)) && !(cap_we && idx == 0);
        if (!legal) begin
          m_err  = 1'b1;
          m_rdat = '0;
        end else begin
          m_ack = 1'b1;
          if (cap_we) begin
            for (int b = 0; b < 4; b++)
              if (cap_sel[b]) mem[idx][8*b +: 8] = cap_wdat[8*b +: 8];
            m_rdat = '0;
          end else begin
            m_rdat = (idx == 0) ? ID : mem[idx];
          end
        end
        pending   = 0;
        idle_from = n + 2;
      end
    end
  end

  bit chk_en = 0;
  always @(negedge in_clock) begin
    if (chk_en) begin
      check("ack", 32'(out_wb_ack), 32'(m_ack));
      check("err", 32'(out_wb_err), 32'(m_err));
      check("rdat", out_wb_rdat, m_rdat);
    end
  end

  // ---------------- master tasks ----------------
  task automatic idle_bus();
    in_wb_cyc = 1'b0; in_wb_stb = 1'b0; in_wb_we = 1'b0;
  endtask

  task automatic xact(input logic we, input logic [21:0] adr, input logic [3:0] sel,
                      input logic [31:0] wdat, input bit extra_stb, input int abort_at,
                      input bit scramble,
                      output logic [31:0] rdat, output logic ack, output logic err,
                      output int lat);
    bit done = 0;
    @(negedge in_clock);
    in_wb_cyc = 1'b1; in_wb_stb = 1'b1; in_wb_we = we;
    in_wb_adr = adr; in_wb_sel = sel; in_wb_wdat = wdat;
    lat = 0; ack = 1'b0; err = 1'b0; rdat = '0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge in_clock);
      if (out_wb_ack || out_wb_err) begin
        ack = out_wb_ack; err = out_wb_err; rdat = out_wb_rdat; lat = c;
        done = 1;
      end else if (abort_at != 0 && c == abort_at) begin
        idle_bus();
        done = 1;
      end else if (scramble && c == 1) begin
        in_wb_adr  = 22'($urandom);
        in_wb_sel  = 4'($urandom);
        in_wb_wdat = $urandom;
        in_wb_we   = 1'($urandom);
      end
    end
    if (!done) check("response_timeout", 32'd0, 32'd1);
    if (extra_stb && lat != 0) @(negedge in_clock);
    idle_bus();
  endtask

  task automatic rd(input int idx, output logic [31:0] data);
    logic a, e; int l;
    xact(1'b0, 22'(idx * 4), 4'hF, '0, 0, 0, 0, data, a, e, l);
    check("rd_ack", 32'(a), 32'd1);
  endtask

  task automatic wr(input int idx, input logic [3:0] sel, input logic [31:0] d);
    logic a, e; int l; logic [31:0] r;
    xact(1'b1, 22'(idx * 4), sel, d, 0, 0, 0, r, a, e, l);
    check("wr_ack", 32'(a), 32'd1);
  endtask

  initial begin
    logic [31:0] r;
    logic a, e;
    int l, acks;
    bit stray;
    in_reset = 1'b1;
    idle_bus();
    in_wb_adr = '0; in_wb_sel = '0; in_wb_wdat = '0;
    @(posedge in_clock);
    chk_en = 1;
    @(posedge in_clock);
    @(negedge in_clock);
    in_reset = 1'b0;
    check("reset_ack", 32'(out_wb_ack), 32'd0);
    check("reset_err", 32'(out_wb_err), 32'd0);
    check("reset_rdat", out_wb_rdat, 32'd0);
    rd(1, r);
    check("word1_after_reset", r, 32'd0);

    // ID read with latency
    xact(1'b0, 22'h000000, 4'hF, '0, 0, 0, 0, r, a, e, l);
    check("id_rdat", r, 32'hB10C_0001);
    check("id_latency", 32'(l), 32'd3);
    check("id_ack", 32'(a), 32'd1);
    @(negedge in_clock);
    check("ack_one_cycle", 32'(out_wb_ack), 32'd0);

    // byte-lane writes
    wr(1, 4'b1111, 32'h0000DAFA);
    wr(1, 4'b0011, 32'h12345678);
    rd(1, r);
    check("byte_lane_rdat", r, 32'h00005678);
    wr(3, 4'b0000, 32'hFFFFFFFF);
    rd(3, r);
    check("sel0_nochange", r, 32'h0);

    // error cases
    xact(1'b0, 22'h000024, 4'hF, '0, 0, 0, 0, r, a, e, l);
    check("oob_err", 32'(e), 32'd1); check("oob_ack", 32'(a), 32'd0); check("oob_rdat", r, 32'd0);
    xact(1'b1, 22'h000000, 4'hF, 32'hFFFF_FFFF, 0, 0, 0, r, a, e, l);
    check("wr_id_err", 32'(e), 32'd1); check("wr_id_ack", 32'(a), 32'd0);
    xact(1'b0, 22'h000006, 4'hF, '0, 0, 0, 0, r, a, e, l);
    check("misalign_err", 32'(e), 32'd1); check("misalign_rdat", r, 32'd0);
    rd(0, r);
    check("id_unchanged", r, ID);
    rd(1, r);
    check("word1_unchanged", r, 32'h00005678);

    // abort during WAIT
    xact(1'b1, 22'h000008, 4'hF, 32'hAAAA5555, 0, 1, 0, r, a, e, l);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge in_clock);
      if (out_wb_ack || out_wb_err) acks++;
    end
    check("abort_no_resp", 32'(acks), 32'd0);
    rd(2, r);
    check("abort_no_write", r, 32'd0);

    // stb held one cycle past ack
    xact(1'b0, 22'h000004, 4'hF, '0, 1, 0, 0, r, a, e, l);
    check("b2b_rdat", r, 32'h00005678);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge in_clock);
      if (out_wb_ack || out_wb_err) acks++;
    end
    check("b2b_single_resp", 32'(acks), 32'd0);

    // reset during WAIT
    @(negedge in_clock);
    in_wb_cyc = 1'b1; in_wb_stb = 1'b1; in_wb_we = 1'b0; in_wb_adr = 22'h000004;
    @(negedge in_clock);
    in_reset = 1'b1;
    idle_bus();
    @(negedge in_clock);
    in_reset = 1'b0;
    check("midreset_ack", 32'(out_wb_ack), 32'd0);
    check("midreset_err", 32'(out_wb_err), 32'd0);
    check("midreset_rdat", out_wb_rdat, 32'd0);
    stray = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge in_clock);
      if (out_wb_ack || out_wb_err) stray = 1;
    end
    check("midreset_no_resp", 32'(stray), 32'd0);
    rd(1, r);
    check("regs_cleared", r, 32'd0);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      int idx, mis, ab;
      if ($urandom_range(0, 4) == 0) begin
        @(negedge in_clock);
        in_wb_stb = 1'b1; in_wb_cyc = 1'b0; in_wb_we = 1'b1;
        @(negedge in_clock);
        idle_bus();
      end
      idx = $urandom_range(0, 9);
      mis = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      ab  = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0;
      xact(1'($urandom), 22'(idx * 4 + mis), 4'($urandom), $urandom,
           ($urandom_range(0, 3) == 0), ab, ($urandom_range(0, 2) == 0), r, a, e, l);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge in_clock);
    end
    repeat (4) @(negedge in_clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wishbone_register_slave.md
Name: wishbone_register_slave

Overview:
Wishbone classic-cycle responder: the slave end of the bus driven by the picobus-to-Wishbone bridge. It holds a bank of 32-bit registers with byte-select writes and a programmable number of wait states. It answers every valid cycle with exactly one ack or err pulse. Used as the bridge's bus peer in simulation and as a generic control/status register block behind the bridge.

Parameters:
NUM_REGS, 8, number of 32-bit words; index 0 is a read-only ID word (legal 2..256)
WAIT_STATES, 2, extra cycles inserted between request capture and response (0..15)
ID_VALUE, 32'hB10C_0001, value returned by a read of word 0

Ports:
in_clock  input  1  sole clock; all logic on rising edge
in_reset  input  1  synchronous, active-high reset
in_wb_cyc  input  1  bus cycle active
in_wb_stb  input  1  strobe; request valid when cyc & stb
in_wb_we  input  1  1 = write, 0 = read
in_wb_adr  input  22  byte address
in_wb_sel  input  4  byte lane enables; bit n covers data[8n+7:8n]
in_wb_wdat  input  32  write data
out_wb_ack  output  1  normal termination, one-cycle pulse
out_wb_err  output  1  error termination, one-cycle pulse
out_wb_rdat  output  32  read data, valid while out_wb_ack=1

Behaviour:
- Reset (in_reset=1 at an edge): out_wb_ack=0, out_wb_err=0, out_wb_rdat=0, state=IDLE, wait counter=0, all writable registers 0. This takes priority over everything, including mid-transaction; an aborted transaction gets no response and no write.
- Word index = in_wb_adr[21:2]. Request is legal when adr[1:0]==0, index<NUM_REGS, and not (we=1 and index==0).
- FSM states: IDLE, WAIT, RESP.
- IDLE: at an edge with cyc&stb=1, latch we/adr/sel/wdat and legality. Go to WAIT with counter=WAIT_STATES-1 if WAIT_STATES>0, else go to RESP. With stb=1 and cyc=0, ignore.
- WAIT: decrement the counter each edge; move to RESP at the edge where counter==0. If cyc=0 at any edge in WAIT, abort to IDLE: no ack, no err, no write.
- Entering RESP, registered outputs for one cycle: legal gives ack=1; illegal gives err=1. ack and err are never both high.
- Legal write: at the RESP-entry edge, bytes with sel[n]=1 are updated from the latched wdat; other bytes hold. sel=4'b0000 is still acked and changes nothing.
- Legal read: rdat = word (index 0 gives ID_VALUE), ignoring sel.
- Illegal request, or any write: rdat=0.
- rdat holds its value after the ack cycle until the next response.
- RESP: unconditionally return to IDLE at the next edge with ack/err low. A new request needs cyc&stb sampled in IDLE, so a master that drops stb on the edge it samples ack never triggers a second access.
- Latency: request sampled at edge k gives ack/err high in the cycle after edge k+WAIT_STATES.
- Inputs are not re-sampled after capture; changes to adr/wdat/sel during WAIT have no effect.

Test Plan:
- Reset then idle: in_reset=1 for 2 cycles, cyc=stb=0 -> ack=err=0, rdat=0; read of word 1 returns 0.
- ID read: adr=22'h000000, we=0, WAIT_STATES=2 -> ack high for exactly one cycle, 3 cycles after request edge; rdat=32'hB10C0001.
- Byte-lane write: write adr=22'h000004, sel=4'b1111, wdat=32'h0000DAFA, then adr=22'h000004, sel=4'b0011, wdat=32'h12345678, then read -> 2 acks, read rdat=32'h00005678.
- Errors: read adr=22'h000024 (index 9 >= 8), write to adr=0, and read adr=22'h000006 (misaligned) -> each gets a single err pulse, ack=0, rdat=0, registers unchanged.
- Abort: start write to word 2 (wdat=32'hAAAA5555), drop cyc during WAIT -> no ack/err; later read of word 2 returns 0.
- Back-to-back and mid-op reset: master keeps stb high one cycle after ack -> exactly one response per captured request. Separately, assert in_reset during WAIT -> no response, outputs 0 on the next cycle.
